// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared definitions for the elevator car and its controller:
//   - floor encodings (FLOOR_0..FLOOR_2, FLOOR_MAX)
//   - travel direction constants (UP / DOWN)
//   - car FSM state encoding (car_state_e)
//   - floor_onehot(): floor number -> one-hot request mask
package elevator_pkg;

  localparam int NUM_FLOORS = 3;

  typedef logic [1:0] floor_t;

  localparam floor_t FLOOR_0   = 2'd0;
  localparam floor_t FLOOR_1   = 2'd1;
  localparam floor_t FLOOR_2   = 2'd2;
  localparam floor_t FLOOR_MAX = FLOOR_2;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef enum logic [1:0] {
    CAR_PARKED = 2'd0,
    CAR_TRAVEL = 2'd1,
    CAR_DOOR   = 2'd2
  } car_state_e;

  // Encoding 2'b11 is never a legal floor; it maps to an empty mask.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    case (f)
      FLOOR_0: m = 3'b001;
      FLOOR_1: m = 3'b010;
      FLOOR_2: m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/elevator_car_if.sv
// elevator_car_if
// Bundle between the elevator controller (master) and the car (slave).
//   Controller -> car : call_btn[2:0], move_cmd, direction, door_open
//   Car -> controller : floor_req[2:0], current_floor[1:0], moving,
//                       door_state, fault, car_state (FSM state for observation)
// Protocol: all controller signals are level-sampled on every rising clk edge;
// there is no handshake. The car decides what to honour from its own state
// (commands ignored in TRAVEL/DOOR, violations flagged on fault).
interface elevator_car_if;
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] call_btn;
  logic                  move_cmd;
  logic                  direction;
  logic                  door_open;

  logic [NUM_FLOORS-1:0] floor_req;
  floor_t                current_floor;
  logic                  moving;
  logic                  door_state;
  logic                  fault;
  car_state_e            car_state;

  modport master (
    output call_btn, move_cmd, direction, door_open,
    input  floor_req, current_floor, moving, door_state, fault, car_state
  );

  modport slave (
    input  call_btn, move_cmd, direction, door_open,
    output floor_req, current_floor, moving, door_state, fault, car_state
  );

endinterface

// File: rtl/elevator_req_latch.sv
// elevator_req_latch
// Per-floor sticky request latch.
//   clk, rst : clock, asynchronous active-high reset
//   set[2:0] : set request bit i
//   clr[2:0] : clear request bit i (wins over set in the same cycle)
//   req[2:0] : latched requests (registered)
module elevator_req_latch
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] set,
  input  logic [NUM_FLOORS-1:0] clr,
  output logic [NUM_FLOORS-1:0] req
);

  logic [NUM_FLOORS-1:0] req_q;
  logic [NUM_FLOORS-1:0] req_d;

  // Clear is applied after set so a coincident press is dropped.
  always_comb begin
    req_d = (req_q | set) & ~clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/elevator_car.sv
// elevator_car
// Three-floor elevator car: position tracking, travel/door timing, request
// latching and protocol-violation detection.
//   Parameters : TRAVEL_CYCLES (2..255) cycles per floor,
//                DOOR_CYCLES   (2..255) cycles of door dwell
//   clk, rst   : clock, asynchronous active-high reset
//   car        : elevator_car_if.slave (commands in, status out)
// All status outputs are decoded from registers only.
module elevator_car
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic           clk,
  input  logic           rst,
  elevator_car_if.slave  car
);

  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  car_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;     // shared travel/door down-counter
  floor_t                floor_q, floor_d;
  logic                  dir_q, dir_d;     // direction latched at TRAVEL entry
  logic                  fault_q, fault_d;
  logic [NUM_FLOORS-1:0] req_clr;
  logic [NUM_FLOORS-1:0] req;
  logic                  move_legal;

  // Up is legal below the top floor, down is legal above the bottom floor.
  assign move_legal = (car.direction == UP)
                      ? (floor_q != FLOOR_MAX)
                      : (floor_q != FLOOR_0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    fault_d = fault_q;
    req_clr = '0;

    case (state_q)
      CAR_PARKED: begin
        if (car.door_open) begin
          // door_open beats move_cmd; current floor request clears on entry
          state_d = CAR_DOOR;
          cnt_d   = DOOR_LOAD;
          req_clr = floor_onehot(floor_q);
        end else if (car.move_cmd) begin
          if (move_legal) begin
            state_d = CAR_TRAVEL;
            dir_d   = car.direction;
            cnt_d   = TRAVEL_LOAD;
          end else begin
            fault_d = 1'b1;
          end
        end
      end

      CAR_TRAVEL: begin
        // Direction and move_cmd are not looked at: the floor always completes.
        if (car.door_open) begin
          fault_d = 1'b1;
        end
        if (cnt_q == 8'd0) begin
          state_d = CAR_PARKED;
          floor_d = (dir_q == UP) ? floor_q + 2'd1 : floor_q - 2'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      CAR_DOOR: begin
        // Holding the clear for the whole dwell drops presses at this floor.
        req_clr = floor_onehot(floor_q);
        if (cnt_q == 8'd0) begin
          state_d = CAR_PARKED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = CAR_PARKED;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CAR_PARKED;
      cnt_q   <= 8'd0;
      floor_q <= FLOOR_0;
      dir_q   <= DOWN;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      fault_q <= fault_d;
    end
  end

  elevator_req_latch u_req_latch (
    .clk (clk),
    .rst (rst),
    .set (car.call_btn),
    .clr (req_clr),
    .req (req)
  );

  assign car.floor_req     = req;
  assign car.current_floor = floor_q;
  assign car.moving        = (state_q == CAR_TRAVEL);
  assign car.door_state    = (state_q == CAR_DOOR);
  assign car.fault         = fault_q;
  assign car.car_state     = state_q;

endmodule
